counter_mod_n: RTL and testbench

//  Parametrised modulo-N counter. Counts up or down, supports synchronous load and clear, and
//  has a count enable. Outputs the binary count plus registered BCD tens/ones digits.

---
 rtl/counter_pkg.sv | 10 +
 rtl/bcd_split.sv | 26 ++
 rtl/counter_mod_n.sv | 76 +++++++
 tb/tb_counter_mod_n.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and the elaboration-time legality check for counter_mod_n.
package counter_pkg;
  localparam int BCD_W       = 4;
  localparam int MAX_MODULUS = 100;

  // True when MODULUS is in range and the binary count can represent MODULUS-1.
  function automatic bit width_ok(input int w, input int m);
    return (m >= 2) && (m <= MAX_MODULUS) && ((longint'(1) << w) >= longint'(m));
  endfunction
endpackage

// File: rtl/bcd_split.sv
// Combinational binary-to-BCD conversion (double-dabble); hundreds digit is dropped since counts stay <= 99.
module bcd_split
  import counter_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [BCD_W-1:0] ten_o,
  output logic [BCD_W-1:0] one_o
);
  localparam int SW = WIDTH + 3*BCD_W;

  always_comb begin
    logic [SW-1:0] s;
    s = {{(3*BCD_W){1'b0}}, bin_i};
    for (int i = 0; i < WIDTH; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (s[WIDTH + d*BCD_W +: BCD_W] >= 4'd5)
          s[WIDTH + d*BCD_W +: BCD_W] = s[WIDTH + d*BCD_W +: BCD_W] + 4'd3;
      end
      s = s << 1;
    end
    ten_o = s[WIDTH + BCD_W +: BCD_W];
    one_o = s[WIDTH +: BCD_W];
  end
endmodule

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with sync clear/load, load saturation flag and registered BCD digits.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] nums,
  output logic [BCD_W-1:0] bcd_ten,
  output logic [BCD_W-1:0] bcd_one,
  output logic             cout,
  output logic             ld_err
);
  if (!width_ok(WIDTH, MODULUS)) begin : g_bad_param
    $error("counter_mod_n: illegal MODULUS/WIDTH combination");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] nums_q, nums_d;
  logic [BCD_W-1:0] ten_q, one_q, ten_d, one_d;
  logic             ld_err_q, ld_err_d;

  always_comb begin
    nums_d   = nums_q;
    ld_err_d = 1'b0;
    if (clr) begin
      nums_d = '0;
    end else if (ld) begin
      if (ld_val > MAX_V) begin
        nums_d   = MAX_V;
        ld_err_d = 1'b1;
      end else begin
        nums_d = ld_val;
      end
    end else if (en) begin
      if (up) nums_d = (nums_q == MAX_V) ? '0    : nums_q + ONE;
      else    nums_d = (nums_q == '0)    ? MAX_V : nums_q - ONE;
    end
  end

  // Digits come from the next-state count so they land on the same edge as nums.
  bcd_split #(.WIDTH(WIDTH)) u_bcd (
    .bin_i (nums_d),
    .ten_o (ten_d),
    .one_o (one_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nums_q   <= '0;
      ten_q    <= '0;
      one_q    <= '0;
      ld_err_q <= 1'b0;
    end else begin
      nums_q   <= nums_d;
      ten_q    <= ten_d;
      one_q    <= one_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign cout    = rstn & en & ~clr & ~ld & (up ? (nums_q == MAX_V) : (nums_q == '0));
  assign nums    = nums_q;
  assign bcd_ten = ten_q;
  assign bcd_one = one_q;
  assign ld_err  = ld_err_q;
endmodule

// File: tb/tb_counter_mod_n.sv
// Scoreboard bench: mod-60 counter plus a mod-24 stage cascaded off its carry-out.
module tb_counter_mod_n;
  localparam int M  = 60;
  localparam int M2 = 24;

  typedef struct {
    int nums;
    int ten;
    int one;
    int err;
    int h;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, ld = 1'b0;
  logic [5:0] ld_val = '0;
  logic [5:0] nums;
  logic [3:0] bcd_ten, bcd_one;
  logic       cout, ld_err;

  logic       h_clr = 1'b1;
  logic [4:0] h_nums;
  logic [3:0] h_ten, h_one;
  logic       h_cout, h_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_nums  = 0;
  int   m_h     = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  counter_mod_n #(.MODULUS(M), .WIDTH(6)) dut (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .ld(ld), .ld_val(ld_val),
    .nums(nums), .bcd_ten(bcd_ten), .bcd_one(bcd_one), .cout(cout), .ld_err(ld_err)
  );

  counter_mod_n #(.MODULUS(M2), .WIDTH(5)) u_hr (
    .clk(clk), .rstn(rstn), .en(cout), .up(1'b1), .clr(h_clr), .ld(1'b0), .ld_val(5'd0),
    .nums(h_nums), .bcd_ten(h_ten), .bcd_one(h_one), .cout(h_cout), .ld_err(h_err)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One clock: drive at negedge, check cout, push expectation, compare after the edge.
  task automatic step(input logic e, input logic u, input logic c, input logic l, input int lv);
    exp_t x, o;
    int   nx, exp_cout;
    en = e; up = u; clr = c; ld = l; ld_val = 6'(lv);
    #1;
    exp_cout = (e && !c && !l && (u ? (m_nums == M-1) : (m_nums == 0))) ? 1 : 0;
    chk("cout", int'(cout), exp_cout);
    if (c)      nx = 0;
    else if (l) nx = (lv >= M) ? M-1 : lv;
    else if (e) nx = u ? ((m_nums == M-1) ? 0 : m_nums + 1) : ((m_nums == 0) ? M-1 : m_nums - 1);
    else        nx = m_nums;
    x.nums = nx; x.ten = nx / 10; x.one = nx % 10;
    x.err  = (!c && l && lv >= M) ? 1 : 0;
    x.h    = h_clr ? 0 : (exp_cout ? ((m_h == M2-1) ? 0 : m_h + 1) : m_h);
    sb.push_back(x);
    m_nums = nx; m_h = x.h;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      o = sb.pop_front();
      chk("nums",    int'(nums),    o.nums);
      chk("bcd_ten", int'(bcd_ten), o.ten);
      chk("bcd_one", int'(bcd_one), o.one);
      chk("ld_err",  int'(ld_err),  o.err);
      chk("h_nums",  int'(h_nums),  o.h);
    end
    @(negedge clk);
  endtask

  initial begin
    int h_prev, h_steps, wrap_cyc;
    // reset state, with en asserted to show cout is masked
    en = 1'b1; up = 1'b1;
    #12;
    chk("rst_nums", int'(nums), 0);
    chk("rst_ten", int'(bcd_ten), 0);
    chk("rst_one", int'(bcd_one), 0);
    chk("rst_err", int'(ld_err), 0);
    chk("rst_cout", int'(cout), 0);
    @(negedge clk);
    rstn = 1'b1;

    // count up through a full wrap
    for (int i = 0; i < M; i++) step(1, 1, 0, 0, 0);
    chk("wrap_up", int'(nums), 0);

    // down from 0 wraps to 59
    step(1, 0, 0, 0, 0);
    chk("down_wrap_ten", int'(bcd_ten), 5);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // loads: in range, out of range, boundaries
    step(0, 1, 0, 1, 45);
    step(0, 1, 0, 1, 63);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 59);
    step(0, 1, 0, 1, 60);
    step(1, 1, 0, 0, 0);

    // priority
    step(1, 1, 1, 1, 30);
    step(1, 1, 0, 1, 30);
    step(1, 1, 1, 0, 0);

    // count to 37 then asynchronous reset mid-cycle
    for (int i = 0; i < 37; i++) step(1, 1, 0, 0, 0);
    chk("pre_rst", int'(nums), 37);
    en = 1'b1; up = 1'b1; clr = 1'b0; ld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_nums", int'(nums), 0);
    chk("mid_rst_ten", int'(bcd_ten), 0);
    chk("mid_rst_one", int'(bcd_one), 0);
    chk("mid_rst_cout", int'(cout), 0);
    m_nums = 0; m_h = 0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);

    // cascade mod-60 -> mod-24
    step(0, 1, 1, 0, 0);
    h_clr = 1'b0;
    chk("casc_start", int'(h_nums), 0);
    h_prev = 0; h_steps = 0; wrap_cyc = -1;
    for (int i = 1; i <= 3600; i++) begin
      step(1, 1, 0, 0, 0);
      if (int'(h_nums) != h_prev) h_steps++;
      if (h_prev == M2-1 && h_nums == 5'd0 && wrap_cyc < 0) wrap_cyc = i;
      h_prev = int'(h_nums);
    end
    chk("casc_steps", h_steps, 60);
    chk("casc_final", int'(h_nums), 60 % M2);
    chk("casc_wrap_cycle", wrap_cyc, 1440);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
